// File: rtl/osw_len_queue_mc.sv
// osw_len_queue_mc: per-channel queues of transfer lengths, split into
// bursts of at most BURST_BYTES and round-robined onto one registered
// output stream.
// Build option: define OSW_LEN_QUEUE_ZERO_DROP_EN to discard accepted
// zero-length entries at the FIFO input. Without it, a zero-length entry
// emits one burst with o_len=0 and o_last=1.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. The producer holds data stable while valid is high and
// ready is low. Output fields never change while o_valid=1 and o_ready=0.
// The output register FSM state is visible on o_valid: HELD=1, EMPTY=0.
module osw_len_queue_mc #(
  parameter int N_CHANNELS  = 2,
  parameter int LEN_BITS    = 32,
  parameter int DEPTH       = 16,
  parameter int BURST_BYTES = 4096,
  localparam int CH_BITS    = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1,
  localparam int FILL_BITS  = $clog2(DEPTH) + 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_CHANNELS*LEN_BITS-1:0]  i_data,
  input  logic [N_CHANNELS-1:0]           i_valid,
  output logic [N_CHANNELS-1:0]           i_ready,
  output logic [LEN_BITS-1:0]             o_len,
  output logic [CH_BITS-1:0]              o_chan,
  output logic                            o_last,
  output logic                            o_valid,
  input  logic                            o_ready,
  output logic [N_CHANNELS*FILL_BITS-1:0] o_fill
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [LEN_BITS-1:0]  BURST_L = LEN_BITS'(BURST_BYTES);
  localparam logic [FILL_BITS-1:0] DEPTH_F = FILL_BITS'(DEPTH);

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_HELD  = 1'b1
  } out_state_e;

  // Per-channel FIFO storage and pointers (one extra bit to tell full from empty)
  logic [LEN_BITS-1:0]  mem_q    [N_CHANNELS][DEPTH];
  logic [FILL_BITS-1:0] wr_ptr_q [N_CHANNELS];
  logic [FILL_BITS-1:0] wr_ptr_d [N_CHANNELS];
  logic [FILL_BITS-1:0] rd_ptr_q [N_CHANNELS];
  logic [FILL_BITS-1:0] rd_ptr_d [N_CHANNELS];
  logic [FILL_BITS-1:0] fill     [N_CHANNELS];
  logic [N_CHANNELS-1:0] push;
  logic [N_CHANNELS-1:0] pop;

  // Current slot per channel: bytes still to be issued for the head entry
  logic [LEN_BITS-1:0]   rem_q [N_CHANNELS];
  logic [LEN_BITS-1:0]   rem_d [N_CHANNELS];
  logic [N_CHANNELS-1:0] active_q;
  logic [N_CHANNELS-1:0] active_d;

  // Arbiter pointer and output register
  logic [CH_BITS-1:0]  rr_ptr_q, rr_ptr_d;
  out_state_e          state_q, state_d;
  logic [LEN_BITS-1:0] len_q, len_d;
  logic [CH_BITS-1:0]  chan_q, chan_d;
  logic                last_q, last_d;

  // FIFO bookkeeping: fill, ready, push/pop decisions and pointer updates
  always_comb begin
    for (int c = 0; c < N_CHANNELS; c++) begin
      fill[c]    = wr_ptr_q[c] - rd_ptr_q[c];
      i_ready[c] = (fill[c] < DEPTH_F);
`ifdef OSW_LEN_QUEUE_ZERO_DROP_EN
      // Zero-length entries complete the handshake but are never stored.
      push[c]    = i_valid[c] && (fill[c] < DEPTH_F) &&
                   (i_data[c*LEN_BITS +: LEN_BITS] != '0);
`else
      push[c]    = i_valid[c] && (fill[c] < DEPTH_F);
`endif
      // A slot reloads only once it has gone idle, so reload costs one cycle.
      pop[c]     = !active_q[c] && (fill[c] != '0);
      wr_ptr_d[c] = wr_ptr_q[c] + FILL_BITS'(push[c]);
      rd_ptr_d[c] = rd_ptr_q[c] + FILL_BITS'(pop[c]);
      o_fill[c*FILL_BITS +: FILL_BITS] = fill[c];
    end
  end

  // Slot loading, round-robin grant and output register next state
  always_comb begin
    logic               may_load;
    logic               found;
    logic [CH_BITS-1:0] gnt;
    logic [CH_BITS-1:0] cand;
    logic [LEN_BITS-1:0] burst;
    logic               last;
    int                 idx;

    rem_d    = rem_q;
    active_d = active_q;
    rr_ptr_d = rr_ptr_q;
    state_d  = state_q;
    len_d    = len_q;
    chan_d   = chan_q;
    last_d   = last_q;
    may_load = (state_q == OUT_EMPTY) || o_ready;
    found    = 1'b0;
    gnt      = '0;
    cand     = '0;
    burst    = '0;
    last     = 1'b0;
    idx      = 0;

    // First active channel at or after rr_ptr, wrapping.
    for (int i = 0; i < N_CHANNELS; i++) begin
      idx  = (int'(rr_ptr_q) + i) % N_CHANNELS;
      cand = CH_BITS'(idx);
      if (!found && active_q[cand]) begin
        found = 1'b1;
        gnt   = cand;
      end
    end

    // Pop and grant never hit the same channel: pop needs an idle slot.
    for (int c = 0; c < N_CHANNELS; c++) begin
      if (pop[c]) begin
        rem_d[c]    = mem_q[c][rd_ptr_q[c][AW-1:0]];
        active_d[c] = 1'b1;
      end
    end

    if (may_load) begin
      if (found) begin
        last  = (rem_q[gnt] <= BURST_L);
        burst = last ? rem_q[gnt] : BURST_L;
        rem_d[gnt] = rem_q[gnt] - burst;
        if (last) begin
          active_d[gnt] = 1'b0;
        end
        if (int'(gnt) == N_CHANNELS - 1) begin
          rr_ptr_d = '0;
        end else begin
          rr_ptr_d = gnt + CH_BITS'(1);
        end
        state_d = OUT_HELD;
        len_d   = burst;
        chan_d  = gnt;
        last_d  = last;
      end else begin
        state_d = OUT_EMPTY;
      end
    end
  end

  // FIFO storage writes (contents need no reset; pointers define validity)
  always_ff @(posedge clk) begin
    for (int c = 0; c < N_CHANNELS; c++) begin
      if (push[c]) begin
        mem_q[c][wr_ptr_q[c][AW-1:0]] <= i_data[c*LEN_BITS +: LEN_BITS];
      end
    end
  end

  // State registers; reset drops every queued and in-flight length
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < N_CHANNELS; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        rem_q[c]    <= '0;
      end
      active_q <= '0;
      rr_ptr_q <= '0;
      state_q  <= OUT_EMPTY;
      len_q    <= '0;
      chan_q   <= '0;
      last_q   <= 1'b0;
    end else begin
      for (int c = 0; c < N_CHANNELS; c++) begin
        wr_ptr_q[c] <= wr_ptr_d[c];
        rd_ptr_q[c] <= rd_ptr_d[c];
        rem_q[c]    <= rem_d[c];
      end
      active_q <= active_d;
      rr_ptr_q <= rr_ptr_d;
      state_q  <= state_d;
      len_q    <= len_d;
      chan_q   <= chan_d;
      last_q   <= last_d;
    end
  end

  assign o_valid = (state_q == OUT_HELD);
  assign o_len   = len_q;
  assign o_chan  = chan_q;
  assign o_last  = last_q;

endmodule

// File: doc/osw_len_queue_mc.md
# osw_len_queue_mc

Multi-channel successor to the output stream writer's length queue. Holds per-channel queues of pending transfer lengths in bytes, splits each length into bursts of at most BURST_BYTES, and round-robins the bursts of all active channels onto one registered output stream. The output stream writer consumes these bursts. Output data is guaranteed stable while o_valid is high and o_ready is low.

## Interface
- N_CHANNELS, 2: number of independent length queues (≥1).
- LEN_BITS, 32: width of a length entry, unsigned bytes.
- DEPTH, 16: entries per channel FIFO, power of two ≥2.
- BURST_BYTES, 4096: maximum burst length, power of two, ≤ 2^(LEN_BITS-1).
- CH_BITS (local) = max(1, $clog2(N_CHANNELS)); FILL_BITS (local) = $clog2(DEPTH)+1.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_data  in  N_CHANNELS*LEN_BITS  per-channel length; channel c occupies bits [c*LEN_BITS +: LEN_BITS].
- i_valid  in  N_CHANNELS  per-channel valid.
- i_ready  out  N_CHANNELS  per-channel ready; high iff that channel's FIFO fill < DEPTH.
- o_len  out  LEN_BITS  burst length in bytes.
- o_chan  out  CH_BITS  channel of the burst.
- o_last  out  1  final burst of the current length entry.
- o_valid  out  1  burst valid.
- o_ready  in  1  consumer ready.
- o_fill  out  N_CHANNELS*FILL_BITS  per-channel FIFO occupancy. Excludes the current slot and the output register.

## Operation
- Per channel: FIFO of DEPTH entries, plus one current slot {remaining[LEN_BITS-1:0], active}.
- Load: when a current slot is inactive and its FIFO is non-empty, pop the head into remaining and set active. Takes one cycle.
- Output register state is either EMPTY (o_valid=0) or HELD (o_valid=1). The register may load when o_valid=0 or o_ready=1.
- Grant: among channels whose current slot is active, pick round-robin starting at rr_ptr. Then:
  - o_len = min(remaining, BURST_BYTES); o_chan = the granted channel.
  - o_last = (remaining ≤ BURST_BYTES).
  - remaining -= o_len.
  - If o_last, the slot goes inactive.
  - rr_ptr = granted channel + 1, wrapping modulo N_CHANNELS.
- If the register may load but no channel is active, o_valid goes to 0.
- In HELD with o_ready=0, o_len, o_chan and o_last do not change. No grant occurs.
- An entry of length L produces ceil(L/BURST_BYTES) bursts. All bursts of that entry carry the same o_chan and are issued in FIFO order. Bursts of different channels may interleave.
- Simultaneous push and pop on one FIFO leaves fill unchanged.
- When full, i_ready=0. A pop in the same cycle does not bypass this.
- Zero-length entries: see Configuration.

## Timing
- Reset (async assert, sync to clk on deassert) puts every output to 0 except i_ready, which is all 1s:
  - o_valid=0, o_len=0, o_chan=0, o_last=0, o_fill=0.
  - All FIFOs emptied, current slots inactive, rr_ptr=0.
- Reset mid-operation discards all queued and in-flight lengths. No burst is emitted after reset for pre-reset entries.
- Latency: an entry accepted at edge E0 into an idle channel is loaded at E1. Its first burst is registered at E2, so o_valid is high after E2.
- Throughput: one burst per cycle while o_ready=1 and any channel is active.
- A channel reloads in the cycle after its last burst is granted. This gives one idle cycle per entry per channel, hidden when another channel is active.
- Buffering capacity per channel: DEPTH (FIFO) + 1 (current slot) + 1 (output register).

## Configuration
- OSW_LEN_QUEUE_ZERO_DROP_EN defined:
  - An accepted length of 0 is discarded at the FIFO input.
  - The handshake completes normally, fill is unchanged, and no burst is emitted.
- Not defined:
  - A length of 0 is queued like any other entry.
  - It emits exactly one burst with o_len=0 and o_last=1.

## Test plan
- Single channel split: N_CHANNELS=2, BURST_BYTES=4096, o_ready=1. Push 10000 on ch0. Expect bursts 4096/4096/1808, o_chan=0, o_last only on the third, first o_valid 2 cycles after acceptance.
- Round-robin: push 8192 on ch0 and ch1 in the same cycle, o_ready=1. Expect o_chan 0,1,0,1 with o_len 4096 each, o_last on the 3rd and 4th bursts.
- Backpressure: during the sequence above, drop o_ready for 5 cycles mid-stream. Expect o_len/o_chan/o_last/o_valid constant for those cycles, and no burst lost or duplicated.
- Full: hold o_ready=0 from reset and push length 100 repeatedly on ch1. Expect exactly DEPTH+2 entries accepted, then i_ready[1]=0 and o_fill ch1 = DEPTH; ch0 i_ready stays 1. Raise o_ready: DEPTH+2 bursts of 100, each with o_last=1.
- Zero length: push 0 then 50 on ch0. With the macro, expect one burst: 50, last. Without it, expect 0/last then 50/last.
- Reset mid-burst: push 20000, assert rst after the second burst. Expect o_valid=0 immediately, o_fill=0, and no further bursts after deassert.
